univ_ff_bank: RTL

//  Bank of WIDTH independent universal flip-flops; each channel runs as D, T, JK or SR per a

---
 rtl/univ_ff_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/univ_ff_bank.sv
// Bank of run-time configurable D/T/JK/SR flip-flops with sticky
// SR-illegal flags and per-channel saturating toggle counters.
module univ_ff_bank #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [2*WIDTH-1:0]     cfg_mode,
  input  logic                   en,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   err_clr,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       sr_err,
  output logic                   any_err,
  output logic [WIDTH*CNT_W-1:0] tog_cnt
);

  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_SR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]       r_q;
  logic [WIDTH-1:0]       r_err;
  logic [2*WIDTH-1:0]     r_mode;
  logic [WIDTH*CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_ill;
  logic [1:0]       w_m;

  // Next-state uses the current (old) mode even when cfg_we is high.
  always_comb begin
    w_q_nxt = r_q;
    w_ill   = '0;
    w_m     = M_D;
    for (int i = 0; i < WIDTH; i++) begin
      w_m = r_mode[2*i +: 2];
      if (en) begin
        case (w_m)
          M_D:  w_q_nxt[i] = a[i];
          M_T:  w_q_nxt[i] = r_q[i] ^ a[i];
          M_JK: begin
            case ({a[i], b[i]})
              2'b10:   w_q_nxt[i] = 1'b1;
              2'b01:   w_q_nxt[i] = 1'b0;
              2'b11:   w_q_nxt[i] = ~r_q[i];
              default: w_q_nxt[i] = r_q[i];
            endcase
          end
          default: begin
            case ({a[i], b[i]})
              2'b10:   w_q_nxt[i] = 1'b1;
              2'b01:   w_q_nxt[i] = 1'b0;
              2'b11:   w_ill[i]   = 1'b1;
              default: w_q_nxt[i] = r_q[i];
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_err  <= '0;
      r_mode <= {WIDTH{M_JK}};
    end else begin
      r_q <= w_q_nxt;
      if (cfg_we)
        r_mode <= cfg_mode;
      // A new illegal event beats err_clr.
      if (err_clr)
        r_err <= w_ill;
      else
        r_err <= r_err | w_ill;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_clr)
          r_cnt[CNT_W*i +: CNT_W] <= '0;
        else if (w_q_nxt[i] != r_q[i] &&
                 r_cnt[CNT_W*i +: CNT_W] != CNT_MAX)
          r_cnt[CNT_W*i +: CNT_W] <=
            r_cnt[CNT_W*i +: CNT_W] + 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign sr_err  = r_err;
  assign any_err = |r_err;
  assign tog_cnt = r_cnt;

endmodule
